// File: rtl/cfg_pkg.sv
// Shared types for the configuration chain master: the fp word type and the cfg FSM/state constants.
package fp;
  localparam int WORD_LENGTH = 16;
  typedef logic [WORD_LENGTH-1:0] fpType;
endpackage

package cfg_pkg;
  localparam int HALF_PERIOD_DEF = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOW    = 2'd1,
    HIGH   = 2'd2,
    FINISH = 2'd3
  } cfg_state_t;
endpackage

// File: rtl/cfg_word_buffer.sv
// CHAIN_LEN-deep word store: append-only write port with fill count, combinational read by index.
module cfg_word_buffer
  import fp::*;
#(
  parameter int CHAIN_LEN = 3,
  parameter int IW        = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1,
  parameter int CW        = $clog2(CHAIN_LEN + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_wr_en,
  input  fpType         i_wr_data,
  input  logic          i_clr,
  input  logic [IW-1:0] i_rd_idx,
  output fpType         o_rd_data,
  output logic [CW-1:0] o_count,
  output logic          o_full
);
  fpType         r_mem [CHAIN_LEN];
  logic [CW-1:0] r_count;
  logic          w_wr;

  assign o_full    = (r_count == CW'(CHAIN_LEN));
  assign w_wr      = i_wr_en && !o_full;
  assign o_count   = r_count;
  assign o_rd_data = r_mem[i_rd_idx];

  always_ff @(posedge clk) begin
    if (reset)       r_count <= '0;
    else if (i_clr)  r_count <= '0;
    else if (w_wr)   r_count <= r_count + 1'b1;
  end

  // Contents are not reset; only the count qualifies them.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_count[IW-1:0]] <= i_wr_data;
  end
endmodule

// File: rtl/config_chain_master.sv
// Transmitting end of the compartment configuration chain: buffers CHAIN_LEN words and shifts them out
// under a slow generated clock. Optional readback of the old chain contents under `CFG_READBACK_EN.
module config_chain_master
  import fp::*;
  import cfg_pkg::*;
#(
  parameter int CHAIN_LEN   = 3,
  parameter int HALF_PERIOD = HALF_PERIOD_DEF
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  wr_valid,
  output logic  wr_ready,
  input  fpType wr_data,
  input  logic  start,
  output logic  busy,
  output logic  done,
  output logic  start_err,
  output logic  cfg_data_clk,
  output fpType cfg_data_out,
  input  fpType cfg_data_return,
  output logic  rd_valid,
  output fpType rd_data
);
  localparam int IW = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;
  localparam int CW = $clog2(CHAIN_LEN + 1);
  localparam int PW = $clog2(HALF_PERIOD) + 1;
  localparam logic [PW-1:0] PH_LOAD  = PW'(HALF_PERIOD - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(CHAIN_LEN - 1);

  cfg_state_t    r_state;
  logic [IW-1:0] r_idx;
  logic [PW-1:0] r_ph;
  logic          r_clk;
  logic          r_start_err;
  fpType         r_dout;

  logic          w_idle, w_full, w_wr_en, w_accept, w_low_last;
  logic [IW-1:0] w_rd_idx;
  logic [CW-1:0] w_count;
  fpType         w_rd_data;

  assign w_idle     = (r_state == IDLE);
  assign wr_ready   = w_idle && !w_full;
  assign w_wr_en    = wr_valid && wr_ready;
  // Full implies no write this cycle, so start is judged on the pre-write count.
  assign w_accept   = start && w_idle && w_full;
  assign w_low_last = (r_state == LOW) && (r_ph == '0);
  assign w_rd_idx   = (r_state == HIGH) ? IW'(r_idx + 1'b1) : '0;

  cfg_word_buffer #(.CHAIN_LEN(CHAIN_LEN), .IW(IW), .CW(CW)) u_buf (
    .clk       (clk),
    .reset     (reset),
    .i_wr_en   (w_wr_en),
    .i_wr_data (wr_data),
    .i_clr     (r_state == FINISH),
    .i_rd_idx  (w_rd_idx),
    .o_rd_data (w_rd_data),
    .o_count   (w_count),
    .o_full    (w_full)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_idx       <= '0;
      r_ph        <= '0;
      r_clk       <= 1'b0;
      r_dout      <= '0;
      r_start_err <= 1'b0;
    end else begin
      r_start_err <= start && !w_accept;
      case (r_state)
        IDLE: if (w_accept) begin
          r_state <= LOW;
          r_ph    <= PH_LOAD;
          r_dout  <= w_rd_data;
        end
        LOW: if (r_ph == '0) begin
          r_state <= HIGH;
          r_ph    <= PH_LOAD;
          r_clk   <= 1'b1;
        end else r_ph <= r_ph - 1'b1;
        HIGH: if (r_ph == '0) begin
          r_clk <= 1'b0;
          if (r_idx == IDX_LAST) r_state <= FINISH;
          else begin
            r_idx   <= r_idx + 1'b1;
            r_state <= LOW;
            r_ph    <= PH_LOAD;
            r_dout  <= w_rd_data;
          end
        end else r_ph <= r_ph - 1'b1;
        FINISH: begin
          r_state <= IDLE;
          r_idx   <= '0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy         = !w_idle;
  assign done         = (r_state == FINISH);
  assign start_err    = r_start_err;
  assign cfg_data_clk = r_clk;
  assign cfg_data_out = r_dout;

`ifdef CFG_READBACK_EN
  logic w_unused;
  assign w_unused = ^w_count;

  // Sampled just before the rising edge, so this is the tail's previous content.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= w_low_last;
      if (w_low_last) rd_data <= cfg_data_return;
    end
  end
`else
  logic w_unused;
  assign w_unused = ^{cfg_data_return, w_count, w_low_last};
  assign rd_valid = 1'b0;
  assign rd_data  = '0;
`endif
endmodule

// File: tb/tb_config_chain_master.sv
// Bench for config_chain_master: HALF_PERIOD=2 and HALF_PERIOD=1 instances sharing the host stimulus,
// each driving a behavioural shift-chain model.
module tb_config_chain_master;
  import fp::*;
  localparam int N = 3;
  typedef fpType words_t [N];

  logic  clk = 1'b0;
  logic  reset, wr_valid, start;
  fpType wr_data;

  logic  wr_ready, busy, done, start_err, cfg_clk, rd_valid;
  fpType cfg_out, cfg_ret, rd_data;
  logic  wr_ready1, busy1, done1, start_err1, cfg_clk1, rd_valid1;
  fpType cfg_out1, cfg_ret1, rd_data1;

  always #5 clk = ~clk;

  config_chain_master #(.CHAIN_LEN(N), .HALF_PERIOD(2)) dut (
    .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .start(start), .busy(busy), .done(done), .start_err(start_err), .cfg_data_clk(cfg_clk),
    .cfg_data_out(cfg_out), .cfg_data_return(cfg_ret), .rd_valid(rd_valid), .rd_data(rd_data));

  config_chain_master #(.CHAIN_LEN(N), .HALF_PERIOD(1)) dut1 (
    .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_ready(wr_ready1), .wr_data(wr_data),
    .start(start), .busy(busy1), .done(done1), .start_err(start_err1), .cfg_data_clk(cfg_clk1),
    .cfg_data_out(cfg_out1), .cfg_data_return(cfg_ret1), .rd_valid(rd_valid1), .rd_data(rd_data1));

  int n_chk = 0, n_fail = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Chain model: index 0 is the first register (E_l), N-1 the last (g_int).
  fpType ch0 [N], ch1 [N];
  always @(posedge cfg_clk) begin
    for (int k = N-1; k > 0; k--) ch0[k] <= ch0[k-1];
    ch0[0] <= cfg_out;
  end
  always @(posedge cfg_clk1) begin
    for (int k = N-1; k > 0; k--) ch1[k] <= ch1[k-1];
    ch1[0] <= cfg_out1;
  end
  assign cfg_ret  = ch0[N-1];
  assign cfg_ret1 = ch1[N-1];

  int busy_c0, busy_c1, done_c0, done_c1, rise0, rise1;
  fpType rdq0[$], rdq1[$];
  always @(posedge clk) begin
    if (busy)  busy_c0++;
    if (busy1) busy_c1++;
    if (done)  done_c0++;
    if (done1) done_c1++;
    if (rd_valid)  rdq0.push_back(rd_data);
    if (rd_valid1) rdq1.push_back(rd_data1);
  end
  always @(posedge cfg_clk)  rise0++;
  always @(posedge cfg_clk1) rise1++;

  // Data must be identical in the cycle before and the cycle of each rising config clock.
  logic pc0, pc1;
  fpType pd0, pd1;
  always @(negedge clk) begin
    if (cfg_clk === 1'b1 && pc0 === 1'b0)  chk("stable_hp2", cfg_out, pd0);
    if (cfg_clk1 === 1'b1 && pc1 === 1'b0) chk("stable_hp1", cfg_out1, pd1);
    pc0 = cfg_clk;  pd0 = cfg_out;
    pc1 = cfg_clk1; pd1 = cfg_out1;
  end

  task automatic clr_mon();
    busy_c0 = 0; busy_c1 = 0; done_c0 = 0; done_c1 = 0; rise0 = 0; rise1 = 0;
    rdq0.delete(); rdq1.delete();
  endtask

  task automatic load(input words_t w);
    for (int k = 0; k < N; k++) begin
      @(negedge clk); wr_valid = 1'b1; wr_data = w[k];
      @(negedge clk); wr_valid = 1'b0;
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int c = 0;
    while ((busy || busy1) && c < 200) begin @(negedge clk); c++; end
    chk($sformatf("%s_timeout", nm), c < 200, 1);
  endtask

  task automatic check_result(input string nm, input words_t w);
    chk($sformatf("%s_busy_hp2", nm), busy_c0, 2*2*N+1);
    chk($sformatf("%s_busy_hp1", nm), busy_c1, 2*1*N+1);
    chk($sformatf("%s_done_hp2", nm), done_c0, 1);
    chk($sformatf("%s_done_hp1", nm), done_c1, 1);
    chk($sformatf("%s_rise_hp2", nm), rise0, N);
    chk($sformatf("%s_rise_hp1", nm), rise1, N);
    for (int k = 0; k < N; k++) begin
      chk($sformatf("%s_reg%0d_hp2", nm, k), ch0[k], w[N-1-k]);
      chk($sformatf("%s_reg%0d_hp1", nm, k), ch1[k], w[N-1-k]);
    end
  endtask

  task automatic run(input string nm, input words_t w, input bit noise);
    words_t old0, old1;
    old0 = ch0; old1 = ch1;
    load(w);
    @(negedge clk); clr_mon();
    pulse_start();
    if (noise) repeat (4) begin @(negedge clk); start = 1'($urandom_range(0, 1)); end
    @(negedge clk); start = 1'b0;
    wait_idle(nm);
    @(negedge clk);
    check_result(nm, w);
`ifdef CFG_READBACK_EN
    if (!$isunknown(old0[0]) && !$isunknown(old0[N-1])) begin
      chk($sformatf("%s_rdn_hp2", nm), rdq0.size(), N);
      chk($sformatf("%s_rdn_hp1", nm), rdq1.size(), N);
      if (rdq0.size() == N && rdq1.size() == N)
        for (int k = 0; k < N; k++) begin
          chk($sformatf("%s_rd%0d_hp2", nm, k), rdq0[k], old0[N-1-k]);
          chk($sformatf("%s_rd%0d_hp1", nm, k), rdq1[k], old1[N-1-k]);
        end
    end
`else
    chk($sformatf("%s_no_rd_hp2", nm), rdq0.size(), 0);
    chk($sformatf("%s_no_rd_hp1", nm), rdq1.size(), 0);
`endif
  endtask

  typedef struct {
    logic v; fpType d; logic s;
    logic rdy; logic err; logic bsy;
  } vec_t;
  vec_t tbl [7];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    words_t w;
    int c;
    tbl[0] = '{1'b1, 16'h1111, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 16'h2222, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[2] = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0}; // start with 2 words
    tbl[3] = '{1'b1, 16'h3333, 1'b1, 1'b1, 1'b1, 1'b0}; // write + start: judged on old count
    tbl[4] = '{1'b1, 16'hDEAD, 1'b0, 1'b0, 1'b0, 1'b0}; // 4th word refused
    tbl[5] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1}; // accepted start
    tbl[6] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1}; // start while busy

    reset = 1'b1; wr_valid = 1'b0; wr_data = '0; start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_wr_ready", wr_ready, 1);
    chk("rst_busy", {busy, busy1}, 0);
    chk("rst_done", {done, done1}, 0);
    chk("rst_start_err", {start_err, start_err1}, 0);
    chk("rst_cfg_clk", {cfg_clk, cfg_clk1}, 0);
    chk("rst_cfg_out", cfg_out, 0);
    chk("rst_rd", {rd_valid, rd_data}, 0);
    @(negedge clk); reset = 1'b0;
    clr_mon();

    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      wr_valid = tbl[i].v; wr_data = tbl[i].d; start = tbl[i].s;
      chk($sformatf("tbl%0d_wr_ready", i), wr_ready, tbl[i].rdy);
      @(posedge clk); #1;
      chk($sformatf("tbl%0d_start_err", i), start_err, tbl[i].err);
      chk($sformatf("tbl%0d_busy", i), busy, tbl[i].bsy);
      if (!tbl[i].bsy) chk($sformatf("tbl%0d_cfg_clk", i), cfg_clk, 0);
    end
    @(negedge clk); wr_valid = 1'b0; start = 1'b0;
    wait_idle("tbl");
    @(negedge clk);
    w = '{16'h1111, 16'h2222, 16'h3333};
    check_result("tbl", w);

    // Reset during the second high phase
    for (int k = 0; k < N; k++) w[k] = fpType'($urandom);
    load(w);
    @(negedge clk); clr_mon();
    pulse_start();
    c = 0;
    while (rise0 < 2 && c < 100) begin @(negedge clk); c++; end
    chk("mid_reset_reach", c < 100, 1);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("mid_reset_cfg_clk", {cfg_clk, cfg_clk1}, 0);
    chk("mid_reset_busy", {busy, busy1}, 0);
    chk("mid_reset_wr_ready", {wr_ready, wr_ready1}, 2'b11);
    chk("mid_reset_done", done, 0);
    @(negedge clk); reset = 1'b0;
    w = '{16'h0F0F, 16'h5A5A, 16'hC3C3};
    run("post_reset", w, 1'b0);

    // Preload AAAA..CCCC (first..last), then two identical runs for readback
    w = '{16'hCCCC, 16'hBBBB, 16'hAAAA};
    run("preload", w, 1'b0);
    w = '{16'h0001, 16'h0002, 16'h0003};
    run("rb1", w, 1'b0);
    run("rb2", w, 1'b0);

    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < N; k++) w[k] = fpType'($urandom);
      run($sformatf("rand%0d", r), w, 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
